// File: rtl/trisc_ir_decode_if.sv
// Bus bundle between the TRISC controller and the instruction register/decoder.
interface trisc_ir_decode_if #(
  parameter int OPW  = 4,
  parameter int ADW  = 4,
  parameter int DW   = 8,
  parameter int ACCW = 8
);
  logic            IRLoad;
  logic [DW-1:0]   MemData;
  logic            AccLoad;
  logic [ACCW-1:0] AccData;
  logic            DecodeAck;

  logic [DW-1:0]   IR;
  logic [ADW-1:0]  Addr;
  logic            LDA, STA, ADD, SUB, XOR, INC, CLR, JMP, JPZ, JPN, HLT;
  logic            Skip, Illegal, DecodeValid;
  logic            ZFlag, NFlag, Halted;
  logic [7:0]      InstrCount;

  modport master (
    output IRLoad, MemData, AccLoad, AccData, DecodeAck,
    input  IR, Addr, LDA, STA, ADD, SUB, XOR, INC, CLR, JMP, JPZ, JPN, HLT,
    input  Skip, Illegal, DecodeValid, ZFlag, NFlag, Halted, InstrCount
  );

  modport slave (
    input  IRLoad, MemData, AccLoad, AccData, DecodeAck,
    output IR, Addr, LDA, STA, ADD, SUB, XOR, INC, CLR, JMP, JPZ, JPN, HLT,
    output Skip, Illegal, DecodeValid, ZFlag, NFlag, Halted, InstrCount
  );
endinterface

// File: rtl/trisc_ir_decode.sv
// TRISC instruction register and one-hot opcode decoder with accumulator flags and sticky halt.
//  state  | meaning
//  EMPTY  | no unconsumed decode, running
//  VALID  | decode lines hold an unconsumed instruction
//  HALT_E | halted, decode consumed
//  HALT_V | halted, HLT decode not yet consumed
module trisc_ir_decode #(
  parameter int OPW  = 4,
  parameter int ADW  = 4,
  parameter int DW   = 8,
  parameter int ACCW = 8
) (
  input logic               SysClock,
  input logic               Reset,
  trisc_ir_decode_if.slave  bus
);
  // bit0 = DecodeValid, bit1 = Halted
  localparam logic [1:0] ST_EMPTY  = 2'b00;
  localparam logic [1:0] ST_VALID  = 2'b01;
  localparam logic [1:0] ST_HALT_E = 2'b10;
  localparam logic [1:0] ST_HALT_V = 2'b11;

  localparam logic [OPW-1:0] OP_LDA = OPW'(0);
  localparam logic [OPW-1:0] OP_STA = OPW'(1);
  localparam logic [OPW-1:0] OP_ADD = OPW'(2);
  localparam logic [OPW-1:0] OP_SUB = OPW'(3);
  localparam logic [OPW-1:0] OP_XOR = OPW'(4);
  localparam logic [OPW-1:0] OP_INC = OPW'(6);
  localparam logic [OPW-1:0] OP_CLR = OPW'(7);
  localparam logic [OPW-1:0] OP_JMP = OPW'(8);
  localparam logic [OPW-1:0] OP_JPZ = OPW'(9);
  localparam logic [OPW-1:0] OP_JPN = OPW'(10);
  localparam logic [OPW-1:0] OP_HLT = OPW'(15);

  localparam int D_LDA = 0, D_STA = 1, D_ADD = 2, D_SUB = 3, D_XOR = 4, D_INC = 5;
  localparam int D_CLR = 6, D_JMP = 7, D_JPZ = 8, D_JPN = 9, D_HLT = 10;

  logic [1:0]    st_q, st_d;
  logic [DW-1:0] ir_q, ir_d;
  logic [10:0]   dec_q, dec_d;
  logic          skip_q, skip_d, ill_q, ill_d;
  logic          z_q, z_d, n_q, n_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [OPW-1:0] opc;
  logic          load;

  always_comb begin
    opc    = bus.MemData[DW-1 -: OPW];
    load   = bus.IRLoad && !st_q[1];
    st_d   = st_q;
    ir_d   = ir_q;
    dec_d  = dec_q;
    skip_d = skip_q;
    ill_d  = ill_q;
    z_d    = z_q;
    n_d    = n_q;
    cnt_d  = cnt_q;

    if (bus.DecodeAck) begin
      dec_d  = '0;
      skip_d = 1'b0;
      ill_d  = 1'b0;
      if (st_q == ST_VALID)       st_d = ST_EMPTY;
      else if (st_q == ST_HALT_V) st_d = ST_HALT_E;
    end

    // a load overrides a simultaneous ack
    if (load) begin
      ir_d   = bus.MemData;
      dec_d  = '0;
      skip_d = 1'b0;
      ill_d  = 1'b0;
      cnt_d  = cnt_q + 8'd1;
      st_d   = ST_VALID;
      case (opc)
        OP_LDA: dec_d[D_LDA] = 1'b1;
        OP_STA: dec_d[D_STA] = 1'b1;
        OP_ADD: dec_d[D_ADD] = 1'b1;
        OP_SUB: dec_d[D_SUB] = 1'b1;
        OP_XOR: dec_d[D_XOR] = 1'b1;
        OP_INC: dec_d[D_INC] = 1'b1;
        OP_CLR: dec_d[D_CLR] = 1'b1;
        OP_JMP: dec_d[D_JMP] = 1'b1;
        OP_JPZ: if (z_q) dec_d[D_JPZ] = 1'b1; else skip_d = 1'b1;
        OP_JPN: if (n_q) dec_d[D_JPN] = 1'b1; else skip_d = 1'b1;
        OP_HLT: begin
          dec_d[D_HLT] = 1'b1;
          st_d         = ST_HALT_V;
        end
        default: ill_d = 1'b1;
      endcase
    end

    // jump qualification above already used the pre-edge flags
    if (bus.AccLoad) begin
      z_d = (bus.AccData == '0);
      n_d = bus.AccData[ACCW-1];
    end
  end

  always_ff @(posedge SysClock or posedge Reset) begin
    if (Reset) begin
      st_q   <= ST_EMPTY;
      ir_q   <= '0;
      dec_q  <= '0;
      skip_q <= 1'b0;
      ill_q  <= 1'b0;
      z_q    <= 1'b1;
      n_q    <= 1'b0;
      cnt_q  <= '0;
    end else begin
      st_q   <= st_d;
      ir_q   <= ir_d;
      dec_q  <= dec_d;
      skip_q <= skip_d;
      ill_q  <= ill_d;
      z_q    <= z_d;
      n_q    <= n_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.IR          = ir_q;
  assign bus.Addr        = ir_q[ADW-1:0];
  assign bus.LDA         = dec_q[D_LDA];
  assign bus.STA         = dec_q[D_STA];
  assign bus.ADD         = dec_q[D_ADD];
  assign bus.SUB         = dec_q[D_SUB];
  assign bus.XOR         = dec_q[D_XOR];
  assign bus.INC         = dec_q[D_INC];
  assign bus.CLR         = dec_q[D_CLR];
  assign bus.JMP         = dec_q[D_JMP];
  assign bus.JPZ         = dec_q[D_JPZ];
  assign bus.JPN         = dec_q[D_JPN];
  assign bus.HLT         = dec_q[D_HLT];
  assign bus.Skip        = skip_q;
  assign bus.Illegal     = ill_q;
  assign bus.DecodeValid = st_q[0];
  assign bus.Halted      = st_q[1];
  assign bus.ZFlag       = z_q;
  assign bus.NFlag       = n_q;
  assign bus.InstrCount  = cnt_q;
endmodule

// File: tb/tb_trisc_ir_decode.sv
// Directed-vector bench for trisc_ir_decode: table of per-edge stimulus/expectations plus reset/wrap sequences.
module tb_trisc_ir_decode;
  logic SysClock = 1'b0;
  logic Reset    = 1'b1;
  int   errors   = 0;
  int   checks   = 0;

  trisc_ir_decode_if bus ();
  trisc_ir_decode dut (.SysClock(SysClock), .Reset(Reset), .bus(bus));

  always #5 SysClock = ~SysClock;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic       ld;  logic [7:0] md;
    logic       al;  logic [7:0] ad;
    logic       ack;
    logic [7:0] e_ir; logic [10:0] e_dec;
    logic       e_sk, e_il, e_v, e_z, e_n, e_h;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t vecs [23];

  // dec packing: {HLT,JPN,JPZ,JMP,CLR,INC,XOR,SUB,ADD,STA,LDA}
  function automatic logic [10:0] dec_now();
    return {bus.HLT, bus.JPN, bus.JPZ, bus.JMP, bus.CLR, bus.INC,
            bus.XOR, bus.SUB, bus.ADD, bus.STA, bus.LDA};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic [7:0] md, input logic al,
                       input logic [7:0] ad, input logic ack);
    bus.IRLoad = ld; bus.MemData = md; bus.AccLoad = al; bus.AccData = ad; bus.DecodeAck = ack;
  endtask

  task automatic step();
    @(posedge SysClock);
    #1;
  endtask

  initial begin
    // {ld, md, al, ad, ack, ir, dec, skip, ill, valid, z, n, halted, cnt}
    vecs[0]  = '{1'b1, 8'h2A, 1'b0, 8'h00, 1'b0, 8'h2A, 11'h004, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h2A, 11'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 8'h80, 1'b0, 8'h2A, 11'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1};
    vecs[3]  = '{1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 8'hA5, 11'h200, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd2};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 8'hA5, 11'h200, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2};
    vecs[5]  = '{1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 8'hA5, 11'h000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3};
    vecs[6]  = '{1'b1, 8'h93, 1'b1, 8'h00, 1'b0, 8'h93, 11'h000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd4};
    vecs[7]  = '{1'b1, 8'h93, 1'b0, 8'h00, 1'b0, 8'h93, 11'h100, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd5};
    vecs[8]  = '{1'b1, 8'h07, 1'b0, 8'h00, 1'b1, 8'h07, 11'h001, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd6};
    vecs[9]  = '{1'b1, 8'h57, 1'b0, 8'h00, 1'b0, 8'h57, 11'h000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd7};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h57, 11'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd7};
    vecs[11] = '{1'b1, 8'h10, 1'b0, 8'h00, 1'b0, 8'h10, 11'h002, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd8};
    vecs[12] = '{1'b1, 8'h3C, 1'b0, 8'h00, 1'b0, 8'h3C, 11'h008, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd9};
    vecs[13] = '{1'b1, 8'h44, 1'b0, 8'h00, 1'b0, 8'h44, 11'h010, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd10};
    vecs[14] = '{1'b1, 8'h61, 1'b0, 8'h00, 1'b0, 8'h61, 11'h020, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd11};
    vecs[15] = '{1'b1, 8'h8F, 1'b0, 8'h00, 1'b0, 8'h8F, 11'h080, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd12};
    vecs[16] = '{1'b1, 8'h7E, 1'b0, 8'h00, 1'b0, 8'h7E, 11'h040, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd13};
    vecs[17] = '{1'b1, 8'hE1, 1'b0, 8'h00, 1'b0, 8'hE1, 11'h000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd14};
    vecs[18] = '{1'b1, 8'hF0, 1'b0, 8'h00, 1'b0, 8'hF0, 11'h400, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd15};
    vecs[19] = '{1'b1, 8'h20, 1'b0, 8'h00, 1'b0, 8'hF0, 11'h400, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd15};
    vecs[20] = '{1'b0, 8'h00, 1'b1, 8'h80, 1'b0, 8'hF0, 11'h400, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd15};
    vecs[21] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'hF0, 11'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd15};
    vecs[22] = '{1'b1, 8'hB1, 1'b0, 8'h00, 1'b1, 8'hF0, 11'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd15};

    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    Reset = 1'b1;
    step();
    step();
    chk("rst.ir", bus.IR, 8'h00);
    chk("rst.valid", bus.DecodeValid, 1'b0);
    Reset = 1'b0;
    repeat (3) step();
    chk("idle.z", bus.ZFlag, 1'b1);
    chk("idle.n", bus.NFlag, 1'b0);
    chk("idle.valid", bus.DecodeValid, 1'b0);
    chk("idle.dec", {dec_now(), bus.Skip, bus.Illegal}, 13'h0);
    chk("idle.cnt", bus.InstrCount, 8'd0);
    chk("idle.halted", bus.Halted, 1'b0);

    for (int i = 0; i < 23; i++) begin
      drive(vecs[i].ld, vecs[i].md, vecs[i].al, vecs[i].ad, vecs[i].ack);
      step();
      chk($sformatf("v%0d.ir", i), bus.IR, vecs[i].e_ir);
      chk($sformatf("v%0d.addr", i), bus.Addr, {28'h0, vecs[i].e_ir[3:0]});
      chk($sformatf("v%0d.dec", i), dec_now(), vecs[i].e_dec);
      chk($sformatf("v%0d.skip", i), bus.Skip, vecs[i].e_sk);
      chk($sformatf("v%0d.illegal", i), bus.Illegal, vecs[i].e_il);
      chk($sformatf("v%0d.valid", i), bus.DecodeValid, vecs[i].e_v);
      chk($sformatf("v%0d.z", i), bus.ZFlag, vecs[i].e_z);
      chk($sformatf("v%0d.n", i), bus.NFlag, vecs[i].e_n);
      chk($sformatf("v%0d.halted", i), bus.Halted, vecs[i].e_h);
      chk($sformatf("v%0d.cnt", i), bus.InstrCount, vecs[i].e_cnt);
    end

    // asynchronous reset while halted, observed before any clock edge
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    Reset = 1'b1;
    #2;
    chk("halt_rst.halted", bus.Halted, 1'b0);
    chk("halt_rst.ir", bus.IR, 8'h00);
    chk("halt_rst.cnt", bus.InstrCount, 8'd0);
    chk("halt_rst.z", bus.ZFlag, 1'b1);
    chk("halt_rst.n", bus.NFlag, 1'b0);
    step();
    Reset = 1'b0;
    step();

    // 256 loads wrap the instruction counter back to zero
    for (int i = 1; i <= 256; i++) begin
      drive(1'b1, 8'h0F, 1'b0, 8'h00, 1'b0);
      step();
      if (i == 255) chk("wrap.cnt255", bus.InstrCount, 8'd255);
    end
    chk("wrap.cnt0", bus.InstrCount, 8'd0);
    chk("wrap.dec", dec_now(), 11'h001);
    chk("wrap.addr", bus.Addr, 4'hF);

    // load with simultaneous ack keeps the new decode valid
    drive(1'b1, 8'h2B, 1'b0, 8'h00, 1'b1);
    step();
    chk("ldack.valid", bus.DecodeValid, 1'b1);
    chk("ldack.dec", dec_now(), 11'h004);
    chk("ldack.cnt", bus.InstrCount, 8'd1);

    // in-flight decode discarded by asynchronous reset
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    #3;
    Reset = 1'b1;
    #1;
    chk("midrst.valid", bus.DecodeValid, 1'b0);
    chk("midrst.dec", dec_now(), 11'h000);
    step();
    Reset = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
